led_tick_bank: RTL and testbench
================================

LED_TICK_BANK -- requirements
Module: led_tick_bank

Interface
REQ-001 SHALL have parameter NUM_CH, default 2: number of independent channels, legal range 1..16.
REQ-002 SHALL have parameter PRESC_W, default 24: prescaler width in bits.
REQ-003 SHALL have parameter CNT_W, default 4: output counter width in bits.
REQ-004 SHALL have parameter SETTLE_CYCLES, default 16: lock-settle length in clk cycles, legal range 1..2^16.
REQ-005 SHALL use one clock and a synchronous, active-high reset.
REQ-006 SHALL have port clk  input  1: the single clock; all logic rises on posedge.
REQ-007 SHALL have port rst  input  1: synchronous active-high reset.
REQ-008 SHALL have port locked  input  1: PLL lock indication, asynchronous to clk.
REQ-009 SHALL have port ch_en  input  NUM_CH: per-channel count enable.
REQ-010 SHALL have port presc_max  input  NUM_CH*PRESC_W: per-channel prescaler terminal value; channel i occupies bits [i*PRESC_W +: PRESC_W].
REQ-011 SHALL have port tick  output  NUM_CH: per-channel one-cycle pulse at prescaler wrap.
REQ-012 SHALL have port cnt_out  output  NUM_CH*CNT_W: per-channel output counters; channel i occupies bits [i*CNT_W +: CNT_W].
REQ-013 SHALL have port running  output  1: high while the FSM is in RUN.

Function
REQ-014 SHALL implement FSM states WAIT_LOCK, SETTLE and RUN, entering WAIT_LOCK on reset.
REQ-015 WAIT_LOCK SHALL move to SETTLE when lock_s=1 and SHALL clear the settle counter.
REQ-016 SETTLE SHALL increment the settle counter each cycle, return to WAIT_LOCK when lock_s=0, and go to RUN when lock_s=1 and the counter equals SETTLE_CYCLES-1.
REQ-017 RUN SHALL return to WAIT_LOCK on any cycle with lock_s=0, with no other exit.
REQ-018 running SHALL be registered and equal to (state==RUN).
REQ-019 A channel SHALL advance only on edges where running=1 before the edge; on any edge where running=0, its prescaler, cnt and tick SHALL clear to 0.
REQ-020 With running=1 and ch_en[i]=1, if prescaler ≥ presc_max[i], the prescaler SHALL wrap to 0, tick[i] SHALL be 1 next cycle, and cnt[i] SHALL increment; otherwise the prescaler SHALL increment and tick[i] SHALL be 0.
REQ-021 The ≥ compare SHALL make a mid-run reduction of presc_max below the current prescaler value wrap on the next edge.
REQ-022 presc_max[i]=0 SHALL give tick[i]=1 on every enabled RUN cycle.
REQ-023 cnt[i] SHALL wrap from 2^CNT_W-1 to 0 modulo 2^CNT_W, with no saturation.
REQ-024 With running=1 and ch_en[i]=0, prescaler and cnt[i] SHALL hold and tick[i] SHALL be 0; re-enabling SHALL resume from the held values.
REQ-025 Latency: with presc_max=M and ch_en held high, the first tick and first cnt change SHALL occur M+1 cycles after running rises.
REQ-026 On lock loss in RUN, channels SHALL advance on that edge, then clear on the next edge.
REQ-027 Channels SHALL be fully independent, so simultaneous wraps on several channels each tick in the same cycle.

Reset
REQ-028 With rst=1 at an edge, state SHALL be WAIT_LOCK and running, tick, cnt_out, all prescalers, the settle counter and the synchroniser flops SHALL all be 0.
REQ-029 rst SHALL override every other input, including mid-RUN.

Configuration
REQ-030 With macro LED_TICK_BANK_SYNC_EN defined, lock_s SHALL be locked through a 2-flop synchroniser reset to 0, adding 2 cycles of latency.
REQ-031 Without LED_TICK_BANK_SYNC_EN, lock_s SHALL equal locked directly, with zero added latency.

Structure
REQ-032 Package led_tick_bank_pkg SHALL hold the FSM state enum (2-bit) and the settle-counter width constant (16).
REQ-033 Sub-module led_tick_chan SHALL implement one channel (prescaler, tick, cnt), instantiated NUM_CH times via generate.

Verification
REQ-034 SHALL verify: SYNC_EN on, SETTLE_CYCLES=4, locked rises at cycle 10 -> running rises at cycle 17.
REQ-035 SHALL verify: NUM_CH=2, presc_max={3,0}, ch_en=2'b11 in RUN -> tick[0] every 4th cycle, tick[1] every cycle; after 16 tick[1] pulses cnt[1]=0 (CNT_W=4).
REQ-036 SHALL verify: locked drops for 1 cycle during SETTLE -> returns to WAIT_LOCK, running stays 0, full settle restarts.
REQ-037 SHALL verify: lock loss in RUN with cnt[0]=5 -> running falls, then cnt[0]=0 and tick=0 one cycle later.
REQ-038 SHALL verify: prescaler at 10, presc_max changed 20→4 -> wrap and tick on the next edge.
REQ-039 SHALL verify: ch_en[0] low for 7 cycles -> cnt[0] and prescaler hold, no tick; resume continues from the held value.

Source files
------------

// File: rtl/led_tick_bank_pkg.sv
// Shared types and constants for the LED tick bank: lock FSM encoding and
// settle-counter width.
package led_tick_bank_pkg;

    typedef enum logic [1:0] {
        ST_WAIT_LOCK = 2'd0,
        ST_SETTLE    = 2'd1,
        ST_RUN       = 2'd2
    } state_e;

    localparam int SETTLE_W = 16;

endpackage

// File: rtl/led_tick_chan.sv
// One tick channel: a prescaler that wraps at a programmable terminal value,
// a one-cycle tick on each wrap and a free-running wrap counter.
module led_tick_chan #(
    parameter int PRESC_W = 24,
    parameter int CNT_W   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_run,
    input  logic               i_en,
    input  logic [PRESC_W-1:0] i_presc_max,
    output logic               o_tick,
    output logic [CNT_W-1:0]   o_cnt
);

    logic [PRESC_W-1:0] r_presc;

    // Prescaler/tick/counter update; the >= compare lets a lowered terminal value take effect at once
    always_ff @(posedge clk) begin
        if (rst || !i_run) begin
            r_presc <= {PRESC_W{1'b0}};
            o_tick  <= 1'b0;
            o_cnt   <= {CNT_W{1'b0}};
        end else if (i_en) begin
            if (r_presc >= i_presc_max) begin
                r_presc <= {PRESC_W{1'b0}};
                o_tick  <= 1'b1;
                o_cnt   <= o_cnt + CNT_W'(1);
            end else begin
                r_presc <= r_presc + PRESC_W'(1);
                o_tick  <= 1'b0;
                o_cnt   <= o_cnt;
            end
        end else begin
            r_presc <= r_presc;
            o_tick  <= 1'b0;
            o_cnt   <= o_cnt;
        end
    end

endmodule

// File: rtl/led_tick_bank.sv
// Bank of independent tick channels gated by a PLL-lock FSM (WAIT_LOCK ->
// SETTLE -> RUN). Define LED_TICK_BANK_SYNC_EN to pass locked through a 2-flop synchroniser.
import led_tick_bank_pkg::*;

module led_tick_bank #(
    parameter int NUM_CH        = 2,
    parameter int PRESC_W       = 24,
    parameter int CNT_W         = 4,
    parameter int SETTLE_CYCLES = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      locked,
    input  logic [NUM_CH-1:0]         ch_en,
    input  logic [NUM_CH*PRESC_W-1:0] presc_max,
    output logic [NUM_CH-1:0]         tick,
    output logic [NUM_CH*CNT_W-1:0]   cnt_out,
    output logic                      running
);

    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);

    state_e              r_state;
    logic [SETTLE_W-1:0] r_settle;
    logic                w_lock_s;

`ifdef LED_TICK_BANK_SYNC_EN
    logic r_sync1;
    logic r_sync2;

    // Two-flop synchroniser for the asynchronous lock input
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= locked;
            r_sync2 <= r_sync1;
        end
    end

    assign w_lock_s = r_sync2;
`else
    assign w_lock_s = locked;
`endif

    // Lock FSM; running is set alongside the state so it matches (state==RUN) exactly
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_WAIT_LOCK;
            r_settle <= {SETTLE_W{1'b0}};
            running  <= 1'b0;
        end else begin
            case (r_state)
                ST_WAIT_LOCK: begin
                    r_settle <= {SETTLE_W{1'b0}};
                    running  <= 1'b0;
                    if (w_lock_s) begin
                        r_state <= ST_SETTLE;
                    end else begin
                        r_state <= ST_WAIT_LOCK;
                    end
                end
                ST_SETTLE: begin
                    r_settle <= r_settle + SETTLE_W'(1);
                    if (!w_lock_s) begin
                        r_state <= ST_WAIT_LOCK;
                        running <= 1'b0;
                    end else if (r_settle == SETTLE_LAST) begin
                        r_state <= ST_RUN;
                        running <= 1'b1;
                    end else begin
                        r_state <= ST_SETTLE;
                        running <= 1'b0;
                    end
                end
                ST_RUN: begin
                    r_settle <= r_settle;
                    if (!w_lock_s) begin
                        r_state <= ST_WAIT_LOCK;
                        running <= 1'b0;
                    end else begin
                        r_state <= ST_RUN;
                        running <= 1'b1;
                    end
                end
                default: begin
                    r_state  <= ST_WAIT_LOCK;
                    r_settle <= {SETTLE_W{1'b0}};
                    running  <= 1'b0;
                end
            endcase
        end
    end

    // Channels see the registered running flag, so they advance one edge behind the FSM
    for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
        led_tick_chan #(
            .PRESC_W (PRESC_W),
            .CNT_W   (CNT_W)
        ) u_chan (
            .clk         (clk),
            .rst         (rst),
            .i_run       (running),
            .i_en        (ch_en[g]),
            .i_presc_max (presc_max[g*PRESC_W +: PRESC_W]),
            .o_tick      (tick[g]),
            .o_cnt       (cnt_out[g*CNT_W +: CNT_W])
        );
    end

endmodule

// File: tb/tb_led_tick_bank.sv
// Scoreboarded bench for led_tick_bank: a lock-streak/channel reference model
// pushes expectations per edge, a negedge monitor pops and compares.
module tb_led_tick_bank;

    localparam int NUM_CH        = 2;
    localparam int PRESC_W       = 8;
    localparam int CNT_W         = 4;
    localparam int SETTLE_CYCLES = 4;
`ifdef LED_TICK_BANK_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif
    localparam int LOCK_TO_RUN = SETTLE_CYCLES + 1 + SYNC_LAT;

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      locked;
    logic [NUM_CH-1:0]         ch_en;
    logic [NUM_CH*PRESC_W-1:0] presc_max;
    logic [NUM_CH-1:0]         tick;
    logic [NUM_CH*CNT_W-1:0]   cnt_out;
    logic                      running;

    led_tick_bank #(
        .NUM_CH        (NUM_CH),
        .PRESC_W       (PRESC_W),
        .CNT_W         (CNT_W),
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .locked    (locked),
        .ch_en     (ch_en),
        .presc_max (presc_max),
        .tick      (tick),
        .cnt_out   (cnt_out),
        .running   (running)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NUM_CH-1:0]       tick;
        logic [NUM_CH*CNT_W-1:0] cnt;
        logic                    running;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;

    // Reference model: running means lock_s has been high for SETTLE_CYCLES+1 consecutive edges
    int m_p[NUM_CH];
    int m_c[NUM_CH];
    bit m_t[NUM_CH];
    bit m_running;
    int m_streak;
    bit m_h1;
    bit m_h2;

    task automatic check(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s: actual=%0d expected=%0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    function automatic void model_edge();
        bit run_before;
        bit ls;
        int m;
        run_before = m_running;
        ls = (SYNC_LAT == 0) ? locked : m_h2;
        if (rst) begin
            m_h1 = 1'b0;
            m_h2 = 1'b0;
            m_streak = 0;
            m_running = 1'b0;
        end else begin
            m_h2 = m_h1;
            m_h1 = locked;
            m_streak = ls ? ((m_streak < 100000) ? m_streak + 1 : m_streak) : 0;
            m_running = (m_streak >= SETTLE_CYCLES + 1);
        end
        for (int i = 0; i < NUM_CH; i++) begin
            m = int'(presc_max[i*PRESC_W +: PRESC_W]);
            if (rst || !run_before) begin
                m_p[i] = 0;
                m_c[i] = 0;
                m_t[i] = 1'b0;
            end else if (ch_en[i]) begin
                if (m_p[i] >= m) begin
                    m_p[i] = 0;
                    m_t[i] = 1'b1;
                    m_c[i] = (m_c[i] + 1) % (1 << CNT_W);
                end else begin
                    m_p[i] = m_p[i] + 1;
                    m_t[i] = 1'b0;
                end
            end else begin
                m_t[i] = 1'b0;
            end
        end
    endfunction

    task automatic step();
        exp_t e;
        @(posedge clk);
        model_edge();
        e.running = m_running;
        for (int i = 0; i < NUM_CH; i++) begin
            e.tick[i] = m_t[i];
            e.cnt[i*CNT_W +: CNT_W] = CNT_W'(m_c[i]);
        end
        exp_q.push_back(e);
        #1;
    endtask

    task automatic wait_running(input logic want, input int limit, output int n);
        n = 0;
        while (running !== want && n < limit) begin
            step();
            n++;
        end
    endtask

    // Monitor: pops one expectation per edge and compares all outputs
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("sb_running", int'(running), int'(mon_e.running));
            check("sb_tick", int'(tick), int'(mon_e.tick));
            check("sb_cnt_out", int'(cnt_out), int'(mon_e.cnt));
        end
    end

    initial begin
        int n;
        int t0;
        int t1;
        int held_c;
        int w;
        rst = 1'b1;
        locked = 1'b0;
        ch_en = '0;
        presc_max = '0;
        m_running = 1'b0;
        m_streak = 0;
        m_h1 = 1'b0;
        m_h2 = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            m_p[i] = 0;
            m_c[i] = 0;
            m_t[i] = 1'b0;
        end

        repeat (3) step();
        check("reset_running", int'(running), 0);
        check("reset_tick", int'(tick), 0);
        check("reset_cnt", int'(cnt_out), 0);
        rst = 1'b0;
        repeat (10) step();
        check("no_lock_running", int'(running), 0);

        // Lock-to-run latency, then ch0 every 4th cycle and ch1 every cycle
        presc_max = {8'd0, 8'd3};
        ch_en = 2'b11;
        locked = 1'b1;
        wait_running(1'b1, 30, n);
        check("lock_to_run", n, LOCK_TO_RUN);
        t0 = 0;
        t1 = 0;
        for (int k = 0; k < 16; k++) begin
            step();
            if (tick[0] === 1'b1) t0++;
            if (tick[1] === 1'b1) t1++;
            if (k == 14) check("cnt1_at_15", int'(cnt_out[CNT_W +: CNT_W]), 15);
        end
        check("tick0_pulses", t0, 4);
        check("tick1_pulses", t1, 16);
        check("cnt1_wrapped", int'(cnt_out[CNT_W +: CNT_W]), 0);
        check("cnt0_after16", int'(cnt_out[0 +: CNT_W]), 4);

        // Lower terminal value below the running prescaler
        presc_max[0 +: PRESC_W] = 8'd20;
        n = 0;
        while (m_p[0] != 10 && n < 40) begin
            step();
            n++;
        end
        check("presc_reached_10", m_p[0], 10);
        presc_max[0 +: PRESC_W] = 8'd4;
        step();
        check("shrink_wrap_tick", int'(tick[0]), 1);

        // Disable ch0 for 7 cycles: hold, no ticks, then resume
        presc_max[0 +: PRESC_W] = 8'd2;
        repeat (5) step();
        held_c = m_c[0];
        ch_en[0] = 1'b0;
        t0 = 0;
        repeat (7) begin
            step();
            if (tick[0] === 1'b1) t0++;
        end
        check("disabled_ticks", t0, 0);
        check("disabled_cnt_hold", int'(cnt_out[0 +: CNT_W]), held_c);
        ch_en[0] = 1'b1;
        repeat (6) step();

        // Lock loss in RUN with cnt0 = 5
        presc_max[0 +: PRESC_W] = 8'd1;
        n = 0;
        while (m_c[0] != 5 && n < 100) begin
            step();
            n++;
        end
        check("cnt0_reached_5", int'(cnt_out[0 +: CNT_W]), 5);
        locked = 1'b0;
        wait_running(1'b0, 10, n);
        check("lock_loss_latency", n, 1 + SYNC_LAT);
        step();
        check("lock_loss_cnt0", int'(cnt_out[0 +: CNT_W]), 0);
        check("lock_loss_tick", int'(tick), 0);

        // One-cycle lock glitch during settle restarts the full settle
        repeat (3) step();
        locked = 1'b1;
        repeat (4) step();
        check("glitch_running_low", int'(running), 0);
        locked = 1'b0;
        step();
        locked = 1'b1;
        wait_running(1'b1, 30, n);
        check("glitch_restart", n, LOCK_TO_RUN);

        // Randomized traffic with occasional lock drops and resets
        for (int k = 0; k < 800; k++) begin
            if ($urandom_range(0, 39) == 0) locked = ~locked;
            rst = ($urandom_range(0, 199) == 0);
            for (int i = 0; i < NUM_CH; i++) begin
                ch_en[i] = ($urandom_range(0, 4) != 0);
                if ($urandom_range(0, 29) == 0)
                    presc_max[i*PRESC_W +: PRESC_W] = PRESC_W'($urandom_range(0, 7));
            end
            step();
        end
        rst = 1'b0;

        w = 0;
        while (exp_q.size() > 0 && w < 10) begin
            @(negedge clk);
            #1;
            w++;
        end
        check("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
